// File: rtl/dmem_copy_engine_pkg.sv
// rtl/dmem_copy_engine_pkg.sv - shared sizes and FSM encoding for the data-memory copy engine
package dmem_copy_engine_pkg;
  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int MEM_DEPTH_DEF = 8;
  localparam int LEN_W_DEF     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/dmem_port_mux.sv
// rtl/dmem_port_mux.sv - selects core or copy engine as the data-memory initiator
module dmem_port_mux
  import dmem_copy_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              sel_engine,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_we,
  input  logic              core_re,
  output logic [DATA_W-1:0] core_rdata,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  input  logic              eng_we,
  input  logic              eng_re,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);
  assign mem_access_addr = sel_engine ? eng_addr  : core_addr;
  assign mem_write_data  = sel_engine ? eng_wdata : core_wdata;
  assign mem_write_en    = sel_engine ? eng_we    : core_we;
  assign mem_read        = sel_engine ? eng_re    : core_re;
  // the core never sees engine read data
  assign core_rdata      = sel_engine ? '0 : mem_read_data;
endmodule

// File: rtl/dmem_copy_engine.sv
// rtl/dmem_copy_engine.sv - block copy engine in front of the single-port data memory
module dmem_copy_engine
  import dmem_copy_engine_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_we,
  input  logic              core_re,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);
  state_t            state, state_nx;
  logic [LEN_W-1:0]  idx, len_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [DATA_W-1:0] rd_buf;
  logic              error_q;
  logic              len_zero, len_bad, last;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              eng_we, eng_re;

  assign len_zero = (length == '0);
  assign len_bad  = int'(length) > MEM_DEPTH;
  assign last     = (idx == len_q - LEN_W'(1));

  always_comb begin
    state_nx  = state;
    eng_addr  = '0;
    eng_wdata = '0;
    eng_we    = 1'b0;
    eng_re    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && len_zero)      state_nx = ST_DONE;
        else if (start && !len_bad) state_nx = ST_RD;
      end
      ST_RD: begin
        eng_addr = src_q + ADDR_W'(idx);
        eng_re   = 1'b1;
        state_nx = ST_WR;
      end
      ST_WR: begin
        eng_addr  = dst_q + ADDR_W'(idx);
        eng_wdata = rd_buf;
        eng_we    = 1'b1;
        state_nx  = last ? ST_DONE : ST_RD;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rd_buf  <= '0;
      error_q <= 1'b0;
    end else begin
      state   <= state_nx;
      error_q <= (state == ST_IDLE) && start && len_bad;
      case (state)
        ST_IDLE: if (start && !len_zero && !len_bad) begin
          src_q <= src_addr;
          dst_q <= dst_addr;
          len_q <= length;
          idx   <= '0;
        end
        ST_RD:   rd_buf <= mem_read_data;
        ST_WR:   if (!last) idx <= idx + LEN_W'(1);
        default: ;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign error      = error_q;
  assign core_stall = busy;

  dmem_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .sel_engine      (busy),
    .core_addr       (core_addr),
    .core_wdata      (core_wdata),
    .core_we         (core_we),
    .core_re         (core_re),
    .core_rdata      (core_rdata),
    .eng_addr        (eng_addr),
    .eng_wdata       (eng_wdata),
    .eng_we          (eng_we),
    .eng_re          (eng_re),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );
endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb/tb_dmem_copy_engine.sv - directed self-checking bench for dmem_copy_engine
module tb_dmem_copy_engine;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] src_addr, dst_addr;
  logic [3:0]  length;
  logic        busy, done, error;
  logic [15:0] core_addr, core_wdata, core_rdata;
  logic        core_we, core_re, core_stall;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  logic [15:0] mem [8];
  int          vectors = 0;
  int          miscompares = 0;

  int          busy_n, done_at, wr_n, stall_bad, rdata_bad;
  logic [15:0] rd_addr [$];
  logic [15:0] rv;

  always #5 clk = ~clk;

  assign mem_read_data = mem_read ? mem[mem_access_addr[2:0]] : 16'h0;
  always @(posedge clk) if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;

  dmem_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .error(error),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we), .core_re(core_re),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [15:0] a, input logic [15:0] d);
    core_addr = a; core_wdata = d; core_we = 1'b1;
    tick();
    core_we = 1'b0; core_wdata = '0;
  endtask

  task automatic core_read(input logic [15:0] a, output logic [15:0] d);
    core_addr = a; core_re = 1'b1;
    @(negedge clk);
    d = core_rdata;
    tick();
    core_re = 1'b0;
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [3:0] n);
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Follows one copy to completion, with the core hammering the port while stalled.
  task automatic watch();
    bit seen = 0;
    bit ended = 0;
    busy_n = 0; done_at = 0; wr_n = 0; stall_bad = 0; rdata_bad = 0;
    rd_addr.delete();
    core_we = 1'b1; core_re = 1'b1; core_addr = 16'd5; core_wdata = 16'hDEAD;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) begin busy_n++; seen = 1; end
      if (core_stall !== busy) stall_bad++;
      if (busy && core_rdata !== 16'h0) rdata_bad++;
      if (mem_read) rd_addr.push_back(mem_access_addr);
      if (mem_write_en) wr_n++;
      if (done) begin
        done_at = c;
        core_we = 1'b0; core_re = 1'b0; core_wdata = '0;
      end
      if (!busy && seen) begin ended = 1; tick(); break; end
      tick();
    end
    core_we = 1'b0; core_re = 1'b0;
    chk("copy_completes", 32'(ended), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    core_addr = '0; core_wdata = '0; core_we = 1'b0; core_re = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    tick(); tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    tick();
    rst = 1'b0;

    // core pass-through
    core_write(16'd3, 16'h1234);
    core_addr = 16'd3; core_re = 1'b1;
    @(negedge clk);
    chk("pass_rdata", 32'(core_rdata), 32'h1234);
    chk("pass_busy", 32'(busy), 32'd0);
    chk("pass_memread", 32'(mem_read), 32'd1);
    tick();
    core_re = 1'b0;

    // 4-word copy 0..3 -> 4..7
    for (int i = 0; i < 4; i++) core_write(16'(i), 16'(16'hA0 + i));
    launch(16'd0, 16'd4, 4'd4);
    watch();
    chk("copy4_busy_cycles", 32'(busy_n), 32'd9);
    chk("copy4_done_cycle", 32'(done_at), 32'd9);
    chk("copy4_stall", 32'(stall_bad), 32'd0);
    chk("copy4_core_rdata_zero", 32'(rdata_bad), 32'd0);
    chk("copy4_reads", 32'(rd_addr.size()), 32'd4);
    chk("copy4_writes", 32'(wr_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      core_read(16'(4 + i), rv);
      chk($sformatf("copy4_mem%0d", 4 + i), 32'(rv), 32'(16'hA0 + i));
    end

    // length 0 with a simultaneous core store
    core_addr = 16'd6; core_wdata = 16'h0066; core_we = 1'b1;
    launch(16'd0, 16'd2, 4'd0);
    core_we = 1'b0;
    watch();
    chk("len0_done_cycle", 32'(done_at), 32'd1);
    chk("len0_busy_cycles", 32'(busy_n), 32'd1);
    chk("len0_reads", 32'(rd_addr.size()), 32'd0);
    chk("len0_writes", 32'(wr_n), 32'd0);
    core_read(16'd6, rv);
    chk("len0_core_store", 32'(rv), 32'h0066);

    // length 9 rejected
    launch(16'd0, 16'd2, 4'd9);
    @(negedge clk);
    chk("len9_error", 32'(error), 32'd1);
    chk("len9_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    chk("len9_error_pulse", 32'(error), 32'd0);
    chk("len9_busy2", 32'(busy), 32'd0);
    tick();

    // overlapping ascending copy
    core_write(16'd0, 16'h11); core_write(16'd1, 16'h22);
    core_write(16'd2, 16'h33); core_write(16'd3, 16'h44);
    launch(16'd0, 16'd1, 4'd3);
    watch();
    chk("ovl_busy_cycles", 32'(busy_n), 32'd7);
    for (int i = 0; i < 4; i++) begin
      core_read(16'(i), rv);
      chk($sformatf("ovl_mem%0d", i), 32'(rv), 32'h11);
    end

    // source address wrap
    core_write(16'd7, 16'h77);
    launch(16'hFFFF, 16'h0010, 4'd2);
    watch();
    chk("wrap_reads", 32'(rd_addr.size()), 32'd2);
    if (rd_addr.size() == 2) begin
      chk("wrap_rd0", 32'(rd_addr[0]), 32'hFFFF);
      chk("wrap_rd1", 32'(rd_addr[1]), 32'h0000);
    end
    core_read(16'd0, rv);
    chk("wrap_mem0", 32'(rv), 32'h77);
    core_read(16'd1, rv);
    chk("wrap_mem1", 32'(rv), 32'h77);

    // reset in the second WR cycle, with a stray start while busy
    for (int i = 0; i < 4; i++) core_write(16'(i), 16'(16'hB0 + i));
    for (int i = 4; i < 8; i++) core_write(16'(i), 16'h0);
    launch(16'd0, 16'd4, 4'd4);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2) begin length = 4'd9; start = 1'b1; end
      if (c == 3) begin
        start = 1'b0;
        chk("rstmid_no_error", 32'(error), 32'd0);
        chk("rstmid_rd1", 32'({mem_read, mem_access_addr}), 32'h10001);
      end
      if (c == 4) begin
        chk("rstmid_wr1", 32'({mem_write_en, mem_access_addr}), 32'h10005);
        rst = 1'b1;
      end
      if (c == 5) begin
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_error", 32'(error), 32'd0);
        rst = 1'b0;
      end
      tick();
    end
    core_read(16'd4, rv); chk("rstmid_mem4", 32'(rv), 32'hB0);
    core_read(16'd5, rv); chk("rstmid_mem5", 32'(rv), 32'hB1);
    core_read(16'd6, rv); chk("rstmid_mem6", 32'(rv), 32'h0);
    core_read(16'd7, rv); chk("rstmid_mem7", 32'(rv), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
